// File: rtl/id_stage_pipe_pkg.sv
// Shared decode definitions for the MIPS ID stage.
// Contents:
//   - opcode / funct / REGIMM-rt encodings of the supported instruction set
//   - REGFILE_SIZE: default architectural register count
//   - operand-source and immediate-extension selector enums
//   - decode(): classifies an instruction into operand sources, immediate
//     extension kind and an illegal flag (datapath-width independent)
package id_stage_pipe_pkg;

  localparam int REGFILE_SIZE = 32;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  // R-form function codes
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  // REGIMM branches are distinguished by the rt field
  localparam logic [4:0] RT_BLTZ = 5'd0;
  localparam logic [4:0] RT_BGEZ = 5'd1;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_RS,
    SRC_RT,
    SRC_SHAMT
  } src_sel_e;

  typedef enum logic [1:0] {
    EXT_NONE,
    EXT_SIGN16,
    EXT_ZERO16,
    EXT_ZERO26
  } ext_sel_e;

  typedef struct packed {
    src_sel_e src1;
    src_sel_e src2;
    ext_sel_e ext;
    logic     illegal;
  } dec_t;

  // Unsupported encodings leave every selector at NONE, so operands and
  // immediate come out as zero without extra gating downstream.
  function automatic dec_t decode(input logic [5:0] op,
                                  input logic [5:0] funct,
                                  input logic [4:0] rt);
    dec_t d;
    d = '{src1: SRC_NONE, src2: SRC_NONE, ext: EXT_NONE, illegal: 1'b0};
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            d.src1 = SRC_RS;
            d.src2 = SRC_RT;
          end
          FN_SLL, FN_SRL, FN_SRA: begin
            d.src1 = SRC_RT;
            d.src2 = SRC_SHAMT;
          end
          FN_SLLV, FN_SRLV, FN_SRAV: begin
            d.src1 = SRC_RT;
            d.src2 = SRC_RS;
          end
          FN_MTHI, FN_MTLO, FN_JR, FN_JALR: d.src1 = SRC_RS;
          FN_MFHI, FN_MFLO: ;
          default: d.illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW: begin
        d.src1 = SRC_RS;
        d.ext  = EXT_SIGN16;
      end
      OP_SW, OP_BEQ, OP_BNE: begin
        d.src1 = SRC_RS;
        d.src2 = SRC_RT;
        d.ext  = EXT_SIGN16;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        d.src1 = SRC_RS;
        d.ext  = EXT_ZERO16;
      end
      OP_BLEZ, OP_BGTZ: begin
        d.src1 = SRC_RS;
        d.ext  = EXT_SIGN16;
      end
      OP_REGIMM: begin
        if (rt == RT_BLTZ || rt == RT_BGEZ) begin
          d.src1 = SRC_RS;
          d.ext  = EXT_SIGN16;
        end else begin
          d.illegal = 1'b1;
        end
      end
      OP_J, OP_JAL: d.ext = EXT_ZERO26;
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/id_stage_pipe_if.sv
// Handshake and data bundle of the ID stage.
//   IF side : in_valid / in_ready / Ins
//   WB side : wb_en / wb_addr / wb_data
//   EX side : out_valid / out_ready, Rdata1, Rdata2, Ed32, rs_o, rt_o, rd_o,
//             shamt_o, op_o, funct_o, illegal
// Modports: master = environment (drives IF, WB and out_ready),
//           slave  = the ID stage itself.
interface id_stage_pipe_if #(
  parameter int DW = 32,
  parameter int AW = 5
) ();
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   Ins;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] Rdata1;
  logic [DW-1:0] Rdata2;
  logic [DW-1:0] Ed32;
  logic [AW-1:0] rs_o;
  logic [AW-1:0] rt_o;
  logic [AW-1:0] rd_o;
  logic [4:0]    shamt_o;
  logic [5:0]    op_o;
  logic [5:0]    funct_o;
  logic          illegal;

  modport master (
    output in_valid, Ins, wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, Rdata1, Rdata2, Ed32, rs_o, rt_o, rd_o,
           shamt_o, op_o, funct_o, illegal
  );

  modport slave (
    input  in_valid, Ins, wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, Rdata1, Rdata2, Ed32, rs_o, rt_o, rd_o,
           shamt_o, op_o, funct_o, illegal
  );
endinterface

// File: rtl/id_stage_pipe_regfile.sv
// NREG x DW register file, two combinational read ports, one write port.
//   clk_i, rst_i        : clock, asynchronous active-high reset (clears all)
//   we_i, waddr_i, wdata_i : write port, lands on the rising edge
//   raddr1_i/raddr2_i   : read addresses
//   rdata1_o/rdata2_o   : read data, write-first (a same-cycle write to the
//                         addressed register is forwarded)
// Register 0 is hardwired to zero: never written, always read as zero.
module id_stage_pipe_regfile #(
  parameter int  DW   = 32,
  parameter int  NREG = 32,
  localparam int AW   = $clog2(NREG)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr1_i,
  input  logic [AW-1:0] raddr2_i,
  output logic [DW-1:0] rdata1_o,
  output logic [DW-1:0] rdata2_o
);

  logic [DW-1:0] regs_q [NREG];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_i && waddr_i != '0) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Zero check last so a write aimed at $zero can never be forwarded.
  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    if (we_i && waddr_i == raddr1_i) rdata1_o = wdata_i;
    if (raddr1_i == '0) rdata1_o = '0;
  end

  always_comb begin
    rdata2_o = regs_q[raddr2_i];
    if (we_i && waddr_i == raddr2_i) rdata2_o = wdata_i;
    if (raddr2_i == '0) rdata2_o = '0;
  end

endmodule

// File: rtl/id_stage_pipe.sv
// MIPS instruction-decode stage between IF and EX.
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : id_stage_pipe_if.slave
//              IF side in_valid/in_ready/Ins, write-back wb_en/wb_addr/wb_data,
//              registered ID/EX outputs out_valid/out_ready, Rdata1, Rdata2,
//              Ed32, rs_o, rt_o, rd_o, shamt_o, op_o, funct_o, illegal.
// Decodes Ins combinationally, reads operands from the register file (with
// write-back bypass) and captures everything into the ID/EX register with
// one cycle of latency under valid/ready flow control. While the ID/EX
// register is stalled, write-backs to its source registers refresh the
// held operands so EX never consumes a stale value.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int  DW   = 32,
  parameter int  NREG = REGFILE_SIZE,
  localparam int AW   = $clog2(NREG)
) (
  input logic            CLK,
  input logic            RST,
  id_stage_pipe_if.slave bus
);

  function automatic logic [DW-1:0] ext_imm(input ext_sel_e    sel,
                                            input logic [15:0] imm,
                                            input logic [25:0] tgt);
    case (sel)
      EXT_SIGN16: ext_imm = {{(DW-16){imm[15]}}, imm};
      EXT_ZERO16: ext_imm = {{(DW-16){1'b0}}, imm};
      EXT_ZERO26: ext_imm = {{(DW-26){1'b0}}, tgt};
      default:    ext_imm = '0;
    endcase
  endfunction

  function automatic logic [DW-1:0] zext_shamt(input logic [4:0] s);
    return {{(DW-5){1'b0}}, s};
  endfunction

  // Instruction fields
  logic [5:0]    op_f, funct_f;
  logic [4:0]    rs_f, rt_f, rd_f, shamt_f;
  logic [15:0]   imm16_f;
  logic [25:0]   tgt26_f;
  logic [AW-1:0] rs_a, rt_a, rd_a;
  dec_t          dec;

  assign op_f    = bus.Ins[31:26];
  assign rs_f    = bus.Ins[25:21];
  assign rt_f    = bus.Ins[20:16];
  assign rd_f    = bus.Ins[15:11];
  assign shamt_f = bus.Ins[10:6];
  assign funct_f = bus.Ins[5:0];
  assign imm16_f = bus.Ins[15:0];
  assign tgt26_f = bus.Ins[25:0];
  assign rs_a    = rs_f[AW-1:0];
  assign rt_a    = rt_f[AW-1:0];
  assign rd_a    = rd_f[AW-1:0];
  assign dec     = decode(op_f, funct_f, rt_f);

  // A source that is not a register reads address 0, which yields zero and
  // also marks the held operand as "not refreshable".
  logic [AW-1:0] raddr1, raddr2;
  logic [DW-1:0] rf_rdata1, rf_rdata2;
  logic [DW-1:0] opnd2, ed_val;

  always_comb begin
    case (dec.src1)
      SRC_RS:  raddr1 = rs_a;
      SRC_RT:  raddr1 = rt_a;
      default: raddr1 = '0;
    endcase
    case (dec.src2)
      SRC_RS:  raddr2 = rs_a;
      SRC_RT:  raddr2 = rt_a;
      default: raddr2 = '0;
    endcase
  end

  id_stage_pipe_regfile #(
    .DW  (DW),
    .NREG(NREG)
  ) u_regfile (
    .clk_i   (CLK),
    .rst_i   (RST),
    .we_i    (bus.wb_en),
    .waddr_i (bus.wb_addr),
    .wdata_i (bus.wb_data),
    .raddr1_i(raddr1),
    .raddr2_i(raddr2),
    .rdata1_o(rf_rdata1),
    .rdata2_o(rf_rdata2)
  );

  assign opnd2  = (dec.src2 == SRC_SHAMT) ? zext_shamt(shamt_f) : rf_rdata2;
  assign ed_val = ext_imm(dec.ext, imm16_f, tgt26_f);

  // ID/EX register state
  logic          vld_q, vld_d;
  logic [DW-1:0] r1_q, r1_d, r2_q, r2_d, ed_q, ed_d;
  logic [AW-1:0] src1_q, src1_d, src2_q, src2_d;
  logic [AW-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [4:0]    shamt_q, shamt_d;
  logic [5:0]    op_q, op_d, funct_q, funct_d;
  logic          ill_q, ill_d;
  logic          in_ready, accept;

  assign in_ready = !vld_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    vld_d   = vld_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    ed_d    = ed_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    shamt_d = shamt_q;
    op_d    = op_q;
    funct_d = funct_q;
    ill_d   = ill_q;
    if (accept) begin
      vld_d   = 1'b1;
      r1_d    = rf_rdata1;
      r2_d    = opnd2;
      ed_d    = ed_val;
      src1_d  = raddr1;
      src2_d  = raddr2;
      rs_d    = rs_a;
      rt_d    = rt_a;
      rd_d    = rd_a;
      shamt_d = shamt_f;
      op_d    = op_f;
      funct_d = funct_f;
      ill_d   = dec.illegal;
    end else if (vld_q && !bus.out_ready) begin
      // Stalled: pick up write-backs to the held register sources only.
      if (bus.wb_en && bus.wb_addr != '0 && bus.wb_addr == src1_q) r1_d = bus.wb_data;
      if (bus.wb_en && bus.wb_addr != '0 && bus.wb_addr == src2_q) r2_d = bus.wb_data;
    end else if (bus.out_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_q   <= 1'b0;
      r1_q    <= '0;
      r2_q    <= '0;
      ed_q    <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      shamt_q <= '0;
      op_q    <= '0;
      funct_q <= '0;
      ill_q   <= 1'b0;
    end else begin
      vld_q   <= vld_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      ed_q    <= ed_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      shamt_q <= shamt_d;
      op_q    <= op_d;
      funct_q <= funct_d;
      ill_q   <= ill_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld_q;
  assign bus.Rdata1    = r1_q;
  assign bus.Rdata2    = r2_q;
  assign bus.Ed32      = ed_q;
  assign bus.rs_o      = rs_q;
  assign bus.rt_o      = rt_q;
  assign bus.rd_o      = rd_q;
  assign bus.shamt_o   = shamt_q;
  assign bus.op_o      = op_q;
  assign bus.funct_o   = funct_q;
  assign bus.illegal   = ill_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
module tb_id_stage_pipe;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  id_stage_pipe_if #(.DW(32), .AW(5)) bus ();

  id_stage_pipe #(.DW(32), .NREG(32)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] ed;
    logic        ill;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
    bus.wb_en   = en;
    bus.wb_addr = addr;
    bus.wb_data = data;
  endtask

  // Presents one instruction; the expectation is queued at the negedge
  // before the edge that transfers it. Clears in_valid and wb_en afterwards.
  task automatic issue(input logic [31:0] ins, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] ed,
                       input logic ill, input string nm);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.Ins      = ins;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge CLK);
      if (bus.in_ready === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: in_ready never rose, got 0, expected 1", nm);
    end else begin
      e.r1 = r1; e.r2 = r2; e.ed = ed; e.ill = ill; e.name = nm;
      sb.push_back(e);
    end
    @(posedge CLK);
    #1;
    bus.in_valid = 1'b0;
    bus.wb_en    = 1'b0;
  endtask

  // Monitor: every ID/EX transfer to EX pops and checks one expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RST === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: got Rdata1=%h with empty queue, expected no transfer",
                   bus.Rdata1);
        end else begin
          e = sb.pop_front();
          chk({e.name, ".Rdata1"}, bus.Rdata1, e.r1);
          chk({e.name, ".Rdata2"}, bus.Rdata2, e.r2);
          chk({e.name, ".Ed32"}, bus.Ed32, e.ed);
          chk({e.name, ".illegal"}, {31'b0, bus.illegal}, {31'b0, e.ill});
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    RST           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.Ins       = '0;
    bus.out_ready = 1'b1;
    set_wb(1'b0, 5'd0, 32'h0);

    // Reset state
    cyc();
    cyc();
    chk("rst.out_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("rst.in_ready", {31'b0, bus.in_ready}, 32'h1);
    chk("rst.Rdata1", bus.Rdata1, 32'h0);
    chk("rst.Rdata2", bus.Rdata2, 32'h0);
    chk("rst.Ed32", bus.Ed32, 32'h0);
    RST = 1'b0;
    cyc();

    // Write r5 then read it through ADD r3,r5,r0
    set_wb(1'b1, 5'd5, 32'h0000_1234);
    cyc();
    set_wb(1'b0, 5'd0, 32'h0);
    issue({6'h00, 5'd5, 5'd0, 5'd3, 5'd0, 6'h20}, 32'h1234, 32'h0, 32'h0, 1'b0, "add_r5_r0");

    // Same-cycle write-back bypass
    set_wb(1'b1, 5'd7, 32'h0000_DEAD);
    issue({6'h00, 5'd7, 5'd7, 5'd1, 5'd0, 6'h20}, 32'hDEAD, 32'hDEAD, 32'h0, 1'b0, "bypass_r7");

    // Immediate extension and operand-select variants
    issue({6'h08, 5'd0, 5'd2, 16'h8000}, 32'h0, 32'h0, 32'hFFFF_8000, 1'b0, "addi_sext");
    issue({6'h0D, 5'd5, 5'd2, 16'h8000}, 32'h1234, 32'h0, 32'h0000_8000, 1'b0, "ori_zext");
    issue({6'h00, 5'd0, 5'd5, 5'd2, 5'd4, 6'h00}, 32'h1234, 32'h4, 32'h0, 1'b0, "sll_shamt");
    issue({6'h00, 5'd7, 5'd5, 5'd1, 5'd0, 6'h04}, 32'h1234, 32'hDEAD, 32'h0, 1'b0, "sllv_swap");
    issue({6'h2B, 5'd5, 5'd7, 16'hFFFC}, 32'h1234, 32'hDEAD, 32'hFFFF_FFFC, 1'b0, "sw");
    issue({6'h02, 26'h3FF_FFFF}, 32'h0, 32'h0, 32'h03FF_FFFF, 1'b0, "j_target");
    issue({6'h00, 5'd7, 15'd0, 6'h08}, 32'hDEAD, 32'h0, 32'h0, 1'b0, "jr");
    issue({6'h01, 5'd5, 5'd0, 16'hFFFF}, 32'h1234, 32'h0, 32'hFFFF_FFFF, 1'b0, "bltz");
    cyc();

    // Stall with refresh of the held rt operand
    set_wb(1'b1, 5'd4, 32'h0000_0044);
    cyc();
    set_wb(1'b0, 5'd0, 32'h0);
    bus.out_ready = 1'b0;
    issue({6'h04, 5'd4, 5'd6, 16'h0010}, 32'h44, 32'h9, 32'h10, 1'b0, "beq_stall");
    bus.in_valid = 1'b1;
    bus.Ins      = {6'h00, 5'd4, 5'd6, 5'd8, 5'd0, 6'h21};
    set_wb(1'b1, 5'd6, 32'h0000_0009);
    @(negedge CLK);
    chk("stall0.in_ready", {31'b0, bus.in_ready}, 32'h0);
    chk("stall0.out_valid", {31'b0, bus.out_valid}, 32'h1);
    chk("stall0.Rdata2_old", bus.Rdata2, 32'h0);
    cyc();
    set_wb(1'b0, 5'd0, 32'h0);
    for (int c = 1; c < 3; c++) begin
      @(negedge CLK);
      chk("stall.in_ready", {31'b0, bus.in_ready}, 32'h0);
      chk("stall.Rdata2_new", bus.Rdata2, 32'h9);
      chk("stall.Ed32_hold", bus.Ed32, 32'h10);
      cyc();
    end
    bus.out_ready = 1'b1;
    issue({6'h00, 5'd4, 5'd6, 5'd8, 5'd0, 6'h21}, 32'h44, 32'h9, 32'h0, 1'b0, "addu_after_stall");
    cyc();

    // $zero rule and illegal encodings
    set_wb(1'b1, 5'd0, 32'h0000_00FF);
    cyc();
    set_wb(1'b0, 5'd0, 32'h0);
    issue({6'h00, 5'd0, 5'd0, 5'd1, 5'd0, 6'h20}, 32'h0, 32'h0, 32'h0, 1'b0, "read_r0");
    set_wb(1'b1, 5'd0, 32'h0000_00AB);
    issue({6'h00, 5'd0, 5'd0, 5'd1, 5'd0, 6'h20}, 32'h0, 32'h0, 32'h0, 1'b0, "r0_no_bypass");
    issue({6'h3F, 5'd5, 5'd7, 16'h1234}, 32'h0, 32'h0, 32'h0, 1'b1, "illegal_op");
    issue({6'h00, 5'd5, 5'd7, 5'd1, 5'd0, 6'h3F}, 32'h0, 32'h0, 32'h0, 1'b1, "illegal_funct");
    cyc();

    // Asynchronous reset mid-cycle drops the held instruction
    bus.out_ready = 1'b0;
    issue({6'h08, 5'd5, 5'd1, 16'h0001}, 32'h1234, 32'h0, 32'h1, 1'b0, "addi_flushed");
    #2;
    RST = 1'b1;
    sb.delete();
    set_wb(1'b1, 5'd9, 32'h0000_0077);
    #1;
    chk("arst.out_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("arst.Rdata1", bus.Rdata1, 32'h0);
    chk("arst.Rdata2", bus.Rdata2, 32'h0);
    chk("arst.Ed32", bus.Ed32, 32'h0);
    @(posedge CLK);
    #3;
    RST = 1'b0;
    set_wb(1'b0, 5'd0, 32'h0);
    bus.out_ready = 1'b1;
    cyc();
    issue({6'h00, 5'd5, 5'd9, 5'd3, 5'd0, 6'h20}, 32'h0, 32'h0, 32'h0, 1'b0, "regs_cleared");

    repeat (3) cyc();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
